// File: rtl/coo_dec_if.sv
// rtl/coo_dec_if.sv - stream handshake bundle shared by the sparse input and dense output of coo_dec
interface coo_dec_if #(
    parameter int W = 64
);
    logic [W-1:0] tdata;
    logic         tuser;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/coo_dec.sv
// rtl/coo_dec.sv - streaming COO (row, col, val) to dense row-major matrix decoder
module coo_dec #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16,
    parameter int N_ROWS = 16,
    parameter int N_COLS = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    coo_dec_if.slave    s_axis,
    coo_dec_if.master   m_axis,
    input  logic        err_clr,
    output logic        err_order,
    output logic        err_range,
    output logic [15:0] mat_cnt
);
    localparam int TW = 2 * IDX_W + DATA_W;

    typedef enum logic [1:0] {RUN, FILL, DRAIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   r;
    logic [IDX_W-1:0]   c;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_last;
    logic               drain_flagged;

    logic               free;
    logic               last_pos;
    logic [IDX_W-1:0]   in_row;
    logic [IDX_W-1:0]   in_col;
    logic [DATA_W-1:0]  in_val;
    logic               in_oor;
    logic [2*IDX_W-1:0] key_in;
    logic [2*IDX_W-1:0] key_pos;

    logic               take;
    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic               set_ord;
    logic               set_rng;

    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tuser  = 1'b0;

    assign free     = !out_valid || m_axis.tready;
    assign last_pos = (r == IDX_W'(N_ROWS - 1)) && (c == IDX_W'(N_COLS - 1));
    assign in_row   = s_axis.tdata[TW-1 -: IDX_W];
    assign in_col   = s_axis.tdata[IDX_W+DATA_W-1 -: IDX_W];
    assign in_val   = s_axis.tdata[DATA_W-1:0];
    assign in_oor   = (in_row >= IDX_W'(N_ROWS)) || (in_col >= IDX_W'(N_COLS));
    // Concatenated {row, col} compares unsigned in row-major order.
    assign key_in   = {in_row, in_col};
    assign key_pos  = {r, c};

    always_comb begin
        take      = 1'b0;
        load      = 1'b0;
        load_data = '0;
        set_ord   = 1'b0;
        set_rng   = 1'b0;
        case (state)
            RUN: begin
                if (free && s_axis.tvalid) begin
                    if (s_axis.tuser) begin
                        take    = 1'b1;
                        set_ord = !s_axis.tlast;
                    end else if (in_oor) begin
                        take    = 1'b1;
                        set_rng = 1'b1;
                    end else if (key_in < key_pos) begin
                        take    = 1'b1;
                        set_ord = 1'b1;
                    end else if (key_in == key_pos) begin
                        take      = 1'b1;
                        load      = 1'b1;
                        load_data = in_val;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            FILL: begin
                load = free;
            end
            DRAIN: begin
                take    = s_axis.tvalid;
                set_ord = s_axis.tvalid && !drain_flagged;
            end
            default: begin
                take = 1'b0;
            end
        endcase
    end

    assign s_axis.tready = ap_rst_n && ((state == DRAIN) || take);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state         <= RUN;
            r             <= '0;
            c             <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            drain_flagged <= 1'b0;
            err_order     <= 1'b0;
            err_range     <= 1'b0;
            mat_cnt       <= '0;
        end else begin
            if (free) begin
                out_valid <= load;
                if (load) begin
                    out_data <= load_data;
                    out_last <= last_pos;
                end
            end

            if (load) begin
                if (last_pos) begin
                    r       <= '0;
                    c       <= '0;
                    mat_cnt <= mat_cnt + 16'd1;
                end else if (c == IDX_W'(N_COLS - 1)) begin
                    c <= '0;
                    r <= r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end

            case (state)
                RUN: begin
                    // Finishing the matrix without having seen tlast leaves leftovers to discard.
                    if (load && last_pos) begin
                        if (take && s_axis.tlast) begin
                            state <= RUN;
                        end else begin
                            state         <= DRAIN;
                            drain_flagged <= 1'b0;
                        end
                    end else if (take && s_axis.tlast) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (load && last_pos) state <= RUN;
                end
                DRAIN: begin
                    if (take) drain_flagged <= 1'b1;
                    if (take && s_axis.tlast) state <= RUN;
                end
                default: state <= RUN;
            endcase

            if (set_ord)      err_order <= 1'b1;
            else if (err_clr) err_order <= 1'b0;
            if (set_rng)      err_range <= 1'b1;
            else if (err_clr) err_range <= 1'b0;
        end
    end
endmodule

// File: tb/tb_coo_dec.sv
// tb/tb_coo_dec.sv - scoreboard bench for coo_dec on a 4x4 matrix
module tb_coo_dec;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int TW = 2 * IW + DW;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        err_clr  = 1'b0;
    logic        err_order;
    logic        err_range;
    logic [15:0] mat_cnt;

    coo_dec_if #(.W(TW)) s_if ();
    coo_dec_if #(.W(DW)) m_if ();

    coo_dec #(.DATA_W(DW), .IDX_W(IW), .N_ROWS(NR), .N_COLS(NC)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .err_clr   (err_clr),
        .err_order (err_order),
        .err_range (err_range),
        .mat_cnt   (mat_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [15:0] row;
        logic [15:0] col;
        logic [31:0] val;
        logic        user;
        logic        last;
    } ent_t;

    ent_t        ents[$];
    logic [32:0] sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          beat_cnt = 0;
    bit          bp       = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int row, input int col, input int val, input bit user = 1'b0, input bit last = 1'b0);
        ent_t e;
        e.row  = 16'(row);
        e.col  = 16'(col);
        e.val  = 32'(val);
        e.user = user;
        e.last = last;
        ents.push_back(e);
    endtask

    // Reference: keep the first in-range entry at each strictly increasing position.
    task automatic model_ents();
        logic [31:0] dense[NR*NC];
        int last_key = -1;
        int key;
        foreach (dense[i]) dense[i] = '0;
        foreach (ents[i]) begin
            if (!ents[i].user && ents[i].row < NR && ents[i].col < NC) begin
                key = int'(ents[i].row) * NC + int'(ents[i].col);
                if (key > last_key) begin
                    dense[key] = ents[i].val;
                    last_key   = key;
                end
            end
            if (ents[i].last) begin
                for (int k = 0; k < NR * NC; k++) sb.push_back({k == NR * NC - 1, dense[k]});
                foreach (dense[j]) dense[j] = '0;
                last_key = -1;
            end
        end
    endtask

    task automatic send(input ent_t e);
        bit got = 1'b0;
        s_if.tdata  = {e.row, e.col, e.val};
        s_if.tuser  = e.user;
        s_if.tlast  = e.last;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge ap_clk);
            if (s_if.tready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge ap_clk);
        #1;
        check("s_handshake", got, 1);
    endtask

    task automatic run_ents();
        model_ents();
        foreach (ents[i]) send(ents[i]);
        s_if.tvalid = 1'b0;
        ents.delete();
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge ap_clk);
        repeat (3) @(posedge ap_clk);
        #1;
        check("drain", sb.size(), 0);
    endtask

    task automatic add_basic();
        add(0, 1, 5);
        add(2, 3, 7);
        add(3, 3, 9, 0, 1);
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            m_if.tready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, prev_beat);
                if (m_if.tvalid && m_if.tready) begin
                    beat_cnt++;
                    if (sb.size() == 0) begin
                        check("extra_beat", sb.size(), 1);
                    end else begin
                        exp = sb.pop_front();
                        check("beat", {m_if.tlast, m_if.tdata}, exp);
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_beat  = {1'b1, m_if.tlast, m_if.tdata};
            end
        end
    end

    initial begin
        int base;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_err_order", err_order, 0);
        check("rst_err_range", err_range, 0);
        check("rst_mat_cnt", mat_cnt, 0);
        check("rst_s_tready", s_if.tready, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        add_basic();
        run_ents();
        wait_drain();
        check("basic_mat_cnt", mat_cnt, 1);
        check("basic_err_order", err_order, 0);
        check("basic_err_range", err_range, 0);

        add(0, 0, 0, 1, 1);
        for (int i = 0; i < NR * NC; i++) add(i / NC, i % NC, i + 1, 0, i == NR * NC - 1);
        run_ents();
        wait_drain();
        check("full_mat_cnt", mat_cnt, 3);
        check("full_err_order", err_order, 0);

        add(1, 0, 3);
        add(0, 2, 4);
        add(5, 0, 1);
        add(3, 3, 8, 0, 1);
        run_ents();
        wait_drain();
        check("err_order_set", err_order, 1);
        check("err_range_set", err_range, 1);
        check("err_mat_cnt", mat_cnt, 4);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        check("clr_err_order", err_order, 0);
        check("clr_err_range", err_range, 0);

        add(3, 3, 1);
        add(3, 3, 2, 0, 1);
        run_ents();
        wait_drain();
        check("drain_err_order", err_order, 1);
        check("drain_mat_cnt", mat_cnt, 5);
        add_basic();
        run_ents();
        wait_drain();
        check("after_drain_mat_cnt", mat_cnt, 6);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;

        bp = 1'b1;
        add_basic();
        run_ents();
        wait_drain();
        bp = 1'b0;
        @(posedge ap_clk);
        #1;
        check("bp_mat_cnt", mat_cnt, 7);
        check("bp_err_order", err_order, 0);

        add(3, 3, 9, 0, 1);
        model_ents();
        s_if.tdata  = {ents[0].row, ents[0].col, ents[0].val};
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b1;
        s_if.tvalid = 1'b1;
        ents.delete();
        base = beat_cnt;
        for (int n = 0; n < 200 && beat_cnt - base < 6; n++) @(negedge ap_clk);
        check("rst_mid_beats", beat_cnt - base, 6);
        @(posedge ap_clk);
        #1;
        ap_rst_n    = 1'b0;
        s_if.tvalid = 1'b0;
        @(negedge ap_clk);
        check("rst_mid_s_tready", s_if.tready, 0);
        @(negedge ap_clk);
        check("rst_mid_m_tvalid", m_if.tvalid, 0);
        check("rst_mid_mat_cnt", mat_cnt, 0);
        sb.delete();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        add_basic();
        run_ents();
        wait_drain();
        check("post_rst_mat_cnt", mat_cnt, 1);
        check("post_rst_err_order", err_order, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
